// File: rtl/imem_loader_if.sv
// Boot-loader bus: byte stream in from the boot link, word writes out to instruction memory.
// The master side is the loader; the slave side is the link/memory/core environment.
interface imem_loader_if #(
    parameter int unsigned ADDR_DEPTH = 14
);
    logic                  start;
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  wren;
    logic [ADDR_DEPTH-1:0] waddr;
    logic [31:0]           wdata;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  core_rst_n;

    modport master (
        input  start, rx_data, rx_valid,
        output rx_ready, wren, waddr, wdata, busy, done, err, core_rst_n
    );

    modport slave (
        output start, rx_data, rx_valid,
        input  rx_ready, wren, waddr, wdata, busy, done, err, core_rst_n
    );
endinterface

// File: rtl/imem_loader.sv
// Assembles a length-prefixed little-endian byte stream into 32-bit instruction memory writes.
// Optional trailing checksum byte when IMEM_LOADER_CKSUM_EN is defined.
module imem_loader #(
    parameter int unsigned ADDR_DEPTH     = 14,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic          clk,
    input logic          rst_n,
    imem_loader_if.master bus
);

    localparam int unsigned TimerW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [32:0] MaxWords = 33'd1 << ADDR_DEPTH;
    localparam logic [ADDR_DEPTH:0] WordOne = {{ADDR_DEPTH{1'b0}}, 1'b1};

`ifdef IMEM_LOADER_CKSUM_EN
    typedef enum logic [2:0] {
        StIdle, StLenLo, StLenHi, StData, StWrite, StDone, StError, StCksum
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StLenLo, StLenHi, StData, StWrite, StDone, StError
    } state_e;
`endif

    state_e                state_q, state_d;
    logic [7:0]            len_lo_q;
    logic [15:0]           len_q;
    logic [ADDR_DEPTH:0]   word_idx_q;
    logic [1:0]            byte_idx_q;
    logic [31:0]           asm_q;
    logic [TimerW-1:0]     idle_q;

    logic                  rx_ready_q;
    logic                  wren_q;
    logic [ADDR_DEPTH-1:0] waddr_q;
    logic [31:0]           wdata_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic                  core_rst_n_q;

`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]            sum_q;
`endif

    logic        accept;
    logic [15:0] len_full;
    logic        timed_out;
    logic        last_word;
    logic        counting;
    logic        rdy_d;
    logic        busy_d;
    logic        entering_load;

    always_comb begin
        accept    = bus.rx_valid && rx_ready_q;
        len_full  = {bus.rx_data, len_lo_q};
        timed_out = (TIMEOUT_CYCLES != 0) && !accept &&
                    (idle_q == TimerW'(TIMEOUT_CYCLES - 1));
        last_word = (32'(word_idx_q) + 32'd1) == 32'(len_q);

        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (bus.start) state_d = StLenLo;
            end
            StLenLo: begin
                if (accept)         state_d = StLenHi;
                else if (timed_out) state_d = StError;
            end
            StLenHi: begin
                if (accept) begin
                    if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CKSUM_EN
                        state_d = StCksum;
`else
                        state_d = StDone;
`endif
                    end else if (33'(len_full) > MaxWords) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end else if (timed_out) begin
                    state_d = StError;
                end
            end
            StData: begin
                if (accept && byte_idx_q == 2'd3) state_d = StWrite;
                else if (timed_out)               state_d = StError;
            end
            StWrite: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CKSUM_EN
                    state_d = StCksum;
`else
                    state_d = StDone;
`endif
                end else begin
                    state_d = StData;
                end
            end
`ifdef IMEM_LOADER_CKSUM_EN
            StCksum: begin
                if (accept)         state_d = (bus.rx_data == sum_q) ? StDone : StError;
                else if (timed_out) state_d = StError;
            end
`endif
            default: state_d = StIdle;
        endcase

        counting = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
        rdy_d    = (state_d == StLenLo) || (state_d == StLenHi) || (state_d == StData);
`ifdef IMEM_LOADER_CKSUM_EN
        counting = counting || (state_q == StCksum);
        rdy_d    = rdy_d || (state_d == StCksum);
`endif
        busy_d        = rdy_d || (state_d == StWrite);
        entering_load = (state_d == StLenLo) && (state_q != StLenLo);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            len_lo_q     <= '0;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            idle_q       <= '0;
            rx_ready_q   <= 1'b0;
            wren_q       <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            // Outputs follow the next state so they line up with the state they describe.
            rx_ready_q   <= rdy_d;
            busy_q       <= busy_d;
            core_rst_n_q <= !busy_d;
            done_q       <= (state_d == StDone);
            err_q        <= (state_d == StError);
            wren_q       <= (state_q == StWrite);

            if (state_q == StWrite) begin
                waddr_q    <= word_idx_q[ADDR_DEPTH-1:0];
                wdata_q    <= asm_q;
                word_idx_q <= word_idx_q + WordOne;
            end

            if (entering_load || accept) begin
                idle_q <= '0;
            end else if (counting && TIMEOUT_CYCLES != 0) begin
                idle_q <= idle_q + TimerW'(1);
            end

            if (entering_load) begin
                word_idx_q <= '0;
                byte_idx_q <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
                sum_q      <= '0;
`endif
            end

            if (accept) begin
                unique case (state_q)
                    StLenLo: len_lo_q <= bus.rx_data;
                    StLenHi: len_q    <= len_full;
                    StData: begin
                        asm_q[{byte_idx_q, 3'b000} +: 8] <= bus.rx_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
                        sum_q      <= sum_q + bus.rx_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.wren       = wren_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.core_rst_n = core_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected memory writes are queued as bytes are driven
// and checked by a write monitor; status outputs are checked inline per scenario.
module tb_imem_loader;

    localparam int AD = 4;

    logic clk;
    logic rst_n;

    imem_loader_if #(.ADDR_DEPTH(AD)) bus ();

    imem_loader #(
        .ADDR_DEPTH    (AD),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int low_cnt  = 0;

    logic [AD+31:0] exp_q[$];
    logic [AD+31:0] mon_e;
    logic [31:0]    load_words[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor and ready-low counter.
    always @(negedge clk) begin
        if (bus.busy === 1'b1 && bus.rx_ready === 1'b0) low_cnt++;
        if (bus.wren === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%h data=%h required no write",
                         bus.waddr, bus.wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.waddr, bus.wdata} !== mon_e) begin
                    failures++;
                    $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                             bus.waddr, bus.wdata, mon_e[AD+31:32], mon_e[31:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        int t;
        acc = 1'b0;
        t   = 0;
        bus.rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!acc && t < 64) begin
            @(negedge clk);
            acc = bus.rx_ready;
            @(posedge clk); #1;
            t++;
        end
        bus.rx_valid = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL byte_accept got ready=0 for 64 cycles required ready=1 byte=%h", b);
        end
    endtask

    function automatic int pick_gap(input int maxgap);
        return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 1));
    endfunction

    // Sends length, words from load_words and (if enabled) the checksum trailer.
    task automatic send_load(input int n, input int maxgap, input bit bad_ck);
        logic [7:0]  sum;
        logic [15:0] len;
        logic [31:0] w;
        sum = 8'd0;
        len = 16'(n);
        send_byte(len[7:0], pick_gap(maxgap));
        send_byte(len[15:8], pick_gap(maxgap));
        for (int i = 0; i < n; i++) begin
            w = load_words[i];
            exp_q.push_back({AD'(i), w});
            for (int b = 0; b < 4; b++) begin
                sum = sum + w[8*b +: 8];
                send_byte(w[8*b +: 8], pick_gap(maxgap));
            end
        end
`ifdef IMEM_LOADER_CKSUM_EN
        send_byte(bad_ck ? sum - 8'd1 : sum, pick_gap(maxgap));
`else
        if (bad_ck) sum = 8'd0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 8;
        if (bus.rx_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got %b required 0", bus.rx_ready); end
        if (bus.wren !== 1'b0) begin failures++; $display("FAIL rst_wren got %b required 0", bus.wren); end
        if (bus.waddr !== '0) begin failures++; $display("FAIL rst_waddr got %h required 0", bus.waddr); end
        if (bus.wdata !== 32'd0) begin failures++; $display("FAIL rst_wdata got %h required 0", bus.wdata); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b required 0", bus.busy); end
        if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done got %b required 0", bus.done); end
        if (bus.err !== 1'b0) begin failures++; $display("FAIL rst_err got %b required 0", bus.err); end
        if (bus.core_rst_n !== 1'b1) begin failures++; $display("FAIL rst_core got %b required 1", bus.core_rst_n); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        load_words = '{32'h0000_0013, 32'h0000_006F};
        pulse_start();
        checks += 2;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got %b required 1", bus.busy); end
        if (bus.core_rst_n !== 1'b0) begin failures++; $display("FAIL basic_core got %b required 0", bus.core_rst_n); end
        send_load(2, 0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        checks += 5;
        if (bus.done !== 1'b1) begin failures++; $display("FAIL basic_done got %b required 1", bus.done); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_idle got %b required 0", bus.busy); end
        if (bus.core_rst_n !== 1'b1) begin failures++; $display("FAIL basic_release got %b required 1", bus.core_rst_n); end
        if (bus.err !== 1'b0) begin failures++; $display("FAIL basic_err got %b required 0", bus.err); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL basic_writes got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_gaps();
        load_words = '{32'h0000_0013, 32'h0000_006F};
        low_cnt = 0;
        pulse_start();
        send_load(2, 5, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        checks += 3;
        if (bus.done !== 1'b1) begin failures++; $display("FAIL gaps_done got %b required 1", bus.done); end
        if (low_cnt != 2) begin failures++; $display("FAIL gaps_ready_low got %0d cycles required 2", low_cnt); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL gaps_writes got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        pulse_start();
        send_byte(8'h11, 0);
        send_byte(8'h00, 0);
        repeat (2) begin @(posedge clk); #1; end
        checks += 3;
        if (bus.err !== 1'b1) begin failures++; $display("FAIL ovf_err got %b required 1", bus.err); end
        if (bus.done !== 1'b0) begin failures++; $display("FAIL ovf_done got %b required 0", bus.done); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL ovf_busy got %b required 0", bus.busy); end
        pulse_start();
        checks++;
        if (bus.err !== 1'b0) begin failures++; $display("FAIL ovf_err_clear got %b required 0", bus.err); end
        load_words = {};
        for (int i = 0; i < 16; i++) load_words.push_back($urandom);
        send_load(16, 0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        checks += 3;
        if (bus.done !== 1'b1) begin failures++; $display("FAIL full_done got %b required 1", bus.done); end
        if (bus.waddr !== 4'hF) begin failures++; $display("FAIL full_last_addr got %h required f", bus.waddr); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL full_writes got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        repeat (7) begin @(posedge clk); #1; end
        checks += 2;
        if (bus.err !== 1'b0) begin failures++; $display("FAIL to_early_err got %b required 0", bus.err); end
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL to_early_busy got %b required 1", bus.busy); end
        @(posedge clk); #1;
        checks += 3;
        if (bus.err !== 1'b1) begin failures++; $display("FAIL to_err got %b required 1", bus.err); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL to_busy got %b required 0", bus.busy); end
        if (bus.core_rst_n !== 1'b1) begin failures++; $display("FAIL to_core got %b required 1", bus.core_rst_n); end
        load_words = '{32'hDEAD_BEEF, 32'h0123_4567};
        pulse_start();
        send_load(2, 0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        checks += 3;
        if (bus.done !== 1'b1) begin failures++; $display("FAIL to_reload_done got %b required 1", bus.done); end
        if (bus.err !== 1'b0) begin failures++; $display("FAIL to_reload_err got %b required 0", bus.err); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL to_writes got %0d pending required 0", exp_q.size()); end
    endtask

`ifdef IMEM_LOADER_CKSUM_EN
    task automatic test_cksum();
        load_words = '{32'h0000_0013, 32'h0000_006F};
        pulse_start();
        send_load(2, 0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        checks += 2;
        if (bus.done !== 1'b1) begin failures++; $display("FAIL ck_good_done got %b required 1", bus.done); end
        if (bus.err !== 1'b0) begin failures++; $display("FAIL ck_good_err got %b required 0", bus.err); end
        pulse_start();
        send_load(2, 0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        checks += 3;
        if (bus.err !== 1'b1) begin failures++; $display("FAIL ck_bad_err got %b required 1", bus.err); end
        if (bus.done !== 1'b0) begin failures++; $display("FAIL ck_bad_done got %b required 0", bus.done); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL ck_writes got %0d pending required 0", exp_q.size()); end
    endtask
`endif

    task automatic test_reset_mid_load();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks += 3;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got %b required 0", bus.busy); end
        if (bus.core_rst_n !== 1'b1) begin failures++; $display("FAIL mid_rst_core got %b required 1", bus.core_rst_n); end
        if (bus.rx_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got %b required 0", bus.rx_ready); end
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_rst_stay_idle got %b required 0", bus.busy); end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_timeout();
`ifdef IMEM_LOADER_CKSUM_EN
        test_cksum();
`endif
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
